fifo_mch_th: RTL
================

# fifo_mch_th

Multi-channel synchronous FIFO with per-channel threshold status. It provides CH independent FIFOs of DP words of W bits each, all on one clock, sharing a single storage array. The block serves the single-clock data paths that currently instantiate several separate threshold FIFOs, for example UART/SPI TX/RX channel groups behind one register interface. It adds programmable almost-full/almost-empty levels, per-channel flush, and registered read data.

## Interface
- W, 8, data width in bits
- DP, 16, depth per channel, power of 2, 2..256
- CH, 4, channel count, 1..16
- AW, $clog2(DP), pointer index width (derived, not overridden)
- CW, $clog2(CH) (minimum 1), channel select width (derived)
- clk  in  1  single clock; all logic on posedge
- reset  in  1  synchronous, active-high reset
- wr_en  in  1  write request
- wr_ch  in  CW  target channel for the write
- wr_data  in  W  write data
- rd_en  in  1  read request
- rd_ch  in  CW  source channel for the read
- rd_data  out  W  registered read data
- rd_valid  out  1  rd_data is valid this cycle
- flush_en  in  1  flush request
- flush_ch  in  CW  channel to flush
- cfg_afull_th  in  AW+1  almost-full level, shared by all channels
- cfg_aempty_th  in  AW+1  almost-empty level, shared by all channels
- full  out  CH  per-channel full
- empty  out  CH  per-channel empty
- afull  out  CH  per-channel almost full
- aempty  out  CH  per-channel almost empty
- ch_cnt  out  CH*(AW+1)  per-channel word count, channel i at [i*(AW+1)+:AW+1]
- err_ovf  out  CH  sticky overflow flag (macro-dependent)
- err_udf  out  CH  sticky underflow flag (macro-dependent)
- err_clr  in  1  clears all sticky error flags

## Operation
- Each channel has wr_ptr and rd_ptr of AW+1 bits, and a count of AW+1 bits in the range 0..DP.
- Storage is mem[CH*DP]. The address is {ch, ptr[AW-1:0]}. Pointers wrap modulo 2*DP.
- A write is accepted when wr_en=1, wr_ch<CH and the channel is not full. On accept: data is stored, wr_ptr+1, count+1.
- A read is accepted when rd_en=1, rd_ch<CH and the channel is not empty. On accept: rd_ptr+1, count-1, and the head word is captured into rd_data.
- A write and a read to the same channel in the same cycle are both evaluated against the pre-edge count. The count is unchanged if both are accepted.
- A write and a read to the same empty channel in the same cycle: the write is accepted and the read is rejected as underflow. There is no bypass.
- A write and a read to the same full channel in the same cycle: the read is accepted and the write is rejected as overflow.
- Flush of channel f sets rd_ptr:=wr_ptr and count:=0. Flush has priority over a write or read to channel f in the same cycle; that write or read is dropped and is not flagged as an error.
- A request with a channel index ≥ CH is ignored. Error flags are not set by it.
- Status is combinational from the registered counts:
  - full = (cnt==DP)
  - empty = (cnt==0)
  - afull = (cnt>=cfg_afull_th)
  - aempty = (cnt<=cfg_aempty_th)
- Reset values: all pointers and counts 0; empty=all 1; full=0; afull=0 unless cfg_afull_th==0; aempty=all 1; ch_cnt=0; rd_data=0; rd_valid=0; err_ovf=0; err_udf=0.

## Timing
- A write at edge N is reflected in ch_cnt and status after edge N. A read issued by the next cycle sees the word.
- Read latency is 1 cycle. An accepted rd_en in cycle N gives rd_valid=1 and rd_data in cycle N+1.
- rd_valid is a single-cycle pulse per accepted read. rd_data holds its value until the next accepted read.
- Reads may be issued back-to-back every cycle, on any mix of channels.
- Flush takes effect at the edge it is sampled. Status shows empty in the next cycle.
- Reset asserted mid-operation clears all state at the next edge. Storage contents are not cleared.

## Configuration
- FIFO_MCH_ERR_EN defined:
  - err_ovf[i] is set on a rejected write to full channel i.
  - err_udf[i] is set on a rejected read from empty channel i.
  - Both flags are sticky until err_clr=1 or reset.
  - Set has priority over err_clr in the same cycle.
- FIFO_MCH_ERR_EN undefined:
  - err_ovf and err_udf are tied to 0 and no error registers exist.
  - Reject behaviour is unchanged.

## Structure
- Package fifo_mch_pkg holds:
  - the clog2-based width helper functions
  - the limits MAX_DP=256 and MAX_CH=16
  - a typedef for the per-channel pointer/count struct
- Sub-module fifo_mch_ptr holds one channel's pointers, count, status and error flags. It takes wr_acc, rd_acc, flush and the thresholds as inputs. The top generates it CH times.
- The top keeps the shared memory, the accept/decode logic and the rd_data register.

## Test plan
- Reset, then idle → empty=4'hF, aempty=4'hF, full=0, ch_cnt=0, rd_valid=0.
- DP=16, write 16 words 0x00..0x0F to ch2, then write again with wr_data=0xAA → full[2]=1, ch_cnt ch2=16, 0xAA is dropped, err_ovf[2]=1. Then read 16 times from ch2 → rd_data is 0x00..0x0F, each one cycle after its rd_en.
- cfg_afull_th=12 and cfg_aempty_th=3; write 12 words to ch0 → afull[0] rises after the 12th write edge, aempty[0] falls after the 4th.
- Simultaneous write and read on ch1 holding 5 words → count stays 5. Same operation on empty ch3 → write accepted, rd_valid=0, err_udf[3]=1.
- Interleave ch0 and ch3 traffic over 40 cycles so both pointers wrap → per-channel order is preserved and there is no cross-channel corruption.
- Flush ch1 holding 7 words while wr_en targets ch1 in the same cycle → empty[1]=1 in the next cycle, the write is dropped, and no error flag is set.

Source files
------------

// File: rtl/fifo_mch_pkg.sv
// Shared widths, limits and per-channel state type for the multi-channel threshold FIFO.
package fifo_mch_pkg;

  localparam int MAX_DP = 256;
  localparam int MAX_CH = 16;
  localparam int MAX_PW = $clog2(MAX_DP) + 1;

  // Select width that stays at least one bit wide for a single channel.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  function automatic int ptr_width(input int dp);
    return $clog2(dp) + 1;
  endfunction

  // Fields are sized for MAX_DP; a channel masks its pointers to 2*DP.
  typedef struct packed {
    logic [MAX_PW-1:0] wr_ptr;
    logic [MAX_PW-1:0] rd_ptr;
    logic [MAX_PW-1:0] cnt;
  } ch_state_t;

endpackage

// File: rtl/fifo_mch_ptr.sv
// One channel's pointers, count, threshold status and sticky error flags.
// Error registers exist only when FIFO_MCH_ERR_EN is defined.
module fifo_mch_ptr
  import fifo_mch_pkg::*;
#(
  parameter int DP = 16,
  parameter int AW = $clog2(DP)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_acc,
  input  logic          rd_acc,
  input  logic          flush,
  input  logic          ovf_evt,
  input  logic          udf_evt,
  input  logic          err_clr,
  input  logic [AW:0]   cfg_afull_th,
  input  logic [AW:0]   cfg_aempty_th,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [AW:0]   cnt,
  output logic          full,
  output logic          empty,
  output logic          afull,
  output logic          aempty,
  output logic          err_ovf,
  output logic          err_udf
);

  localparam logic [MAX_PW-1:0] PTR_MASK = MAX_PW'(2 * DP - 1);
  localparam logic [MAX_PW-1:0] DEPTH    = MAX_PW'(DP);

  ch_state_t st_q;

  // Flush wins over any same-cycle access; the top already drops those requests.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= '0;
    end else if (flush) begin
      st_q.rd_ptr <= st_q.wr_ptr;
      st_q.cnt    <= '0;
    end else begin
      if (wr_acc) st_q.wr_ptr <= (st_q.wr_ptr + MAX_PW'(1)) & PTR_MASK;
      if (rd_acc) st_q.rd_ptr <= (st_q.rd_ptr + MAX_PW'(1)) & PTR_MASK;
      if (wr_acc && !rd_acc)      st_q.cnt <= st_q.cnt + MAX_PW'(1);
      else if (rd_acc && !wr_acc) st_q.cnt <= st_q.cnt - MAX_PW'(1);
    end
  end

  assign wr_addr = st_q.wr_ptr[AW-1:0];
  assign rd_addr = st_q.rd_ptr[AW-1:0];
  assign cnt     = st_q.cnt[AW:0];
  assign full    = (st_q.cnt == DEPTH);
  assign empty   = (st_q.cnt == '0);
  assign afull   = (st_q.cnt >= MAX_PW'(cfg_afull_th));
  assign aempty  = (st_q.cnt <= MAX_PW'(cfg_aempty_th));

`ifdef FIFO_MCH_ERR_EN
  logic ovf_q, udf_q;

  // A new event in the clearing cycle keeps its flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_evt | (ovf_q & ~err_clr);
      udf_q <= udf_evt | (udf_q & ~err_clr);
    end
  end

  assign err_ovf = ovf_q;
  assign err_udf = udf_q;
`else
  logic unused_err;
  assign unused_err = ovf_evt | udf_evt | err_clr;
  assign err_ovf    = 1'b0;
  assign err_udf    = 1'b0;
`endif

endmodule

// File: rtl/fifo_mch_th.sv
// Multi-channel synchronous FIFO sharing one storage array, with per-channel
// threshold status and flush. Define FIFO_MCH_ERR_EN for sticky error flags.
module fifo_mch_th
  import fifo_mch_pkg::*;
#(
  parameter  int W  = 8,
  parameter  int DP = 16,
  parameter  int CH = 4,
  localparam int AW = $clog2(DP),
  localparam int CW = clog2_min1(CH)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [CW-1:0]       wr_ch,
  input  logic [W-1:0]        wr_data,
  input  logic                rd_en,
  input  logic [CW-1:0]       rd_ch,
  output logic [W-1:0]        rd_data,
  output logic                rd_valid,
  input  logic                flush_en,
  input  logic [CW-1:0]       flush_ch,
  input  logic [AW:0]         cfg_afull_th,
  input  logic [AW:0]         cfg_aempty_th,
  output logic [CH-1:0]       full,
  output logic [CH-1:0]       empty,
  output logic [CH-1:0]       afull,
  output logic [CH-1:0]       aempty,
  output logic [CH*(AW+1)-1:0] ch_cnt,
  output logic [CH-1:0]       err_ovf,
  output logic [CH-1:0]       err_udf,
  input  logic                err_clr
);

  // Handshake: no backpressure. A write is taken when wr_en is high, wr_ch names
  // an existing channel that is not full and not being flushed; a read likewise
  // when the channel is not empty. Rejected requests are simply dropped.
  logic [W-1:0]  mem [CH*DP];
  logic [CH-1:0] fl_sel, wr_sel, rd_sel, wr_acc, rd_acc;
  logic [AW-1:0] wr_addr_a [CH];
  logic [AW-1:0] rd_addr_a [CH];
  logic [AW-1:0] wr_addr, rd_addr;

  for (genvar i = 0; i < CH; i++) begin : g_ch
    // Channel indices >= CH match no decode line and are ignored.
    assign fl_sel[i] = flush_en && (flush_ch == CW'(i));
    assign wr_sel[i] = wr_en && (wr_ch == CW'(i)) && !fl_sel[i];
    assign rd_sel[i] = rd_en && (rd_ch == CW'(i)) && !fl_sel[i];
    assign wr_acc[i] = wr_sel[i] && !full[i];
    assign rd_acc[i] = rd_sel[i] && !empty[i];

    fifo_mch_ptr #(.DP(DP), .AW(AW)) u_ptr (
      .clk           (clk),
      .reset         (reset),
      .wr_acc        (wr_acc[i]),
      .rd_acc        (rd_acc[i]),
      .flush         (fl_sel[i]),
      .ovf_evt       (wr_sel[i] && full[i]),
      .udf_evt       (rd_sel[i] && empty[i]),
      .err_clr       (err_clr),
      .cfg_afull_th  (cfg_afull_th),
      .cfg_aempty_th (cfg_aempty_th),
      .wr_addr       (wr_addr_a[i]),
      .rd_addr       (rd_addr_a[i]),
      .cnt           (ch_cnt[i*(AW+1) +: AW+1]),
      .full          (full[i]),
      .empty         (empty[i]),
      .afull         (afull[i]),
      .aempty        (aempty[i]),
      .err_ovf       (err_ovf[i]),
      .err_udf       (err_udf[i])
    );
  end

  always_comb begin
    wr_addr = '0;
    rd_addr = '0;
    for (int i = 0; i < CH; i++) begin
      if (wr_acc[i]) wr_addr = wr_addr_a[i];
      if (rd_acc[i]) rd_addr = rd_addr_a[i];
    end
  end

  // Storage is never reset; only pointers define what is valid.
  always_ff @(posedge clk) begin
    if (|wr_acc) mem[{wr_ch, wr_addr}] <= wr_data;
  end

  // A same-cycle write never targets the head slot being read, so no bypass is needed.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= |rd_acc;
      if (|rd_acc) rd_data <= mem[{rd_ch, rd_addr}];
    end
  end

endmodule
